// File: rtl/dcp_hex_tx.sv
// Hex ASCII print stage: turns one latched status word into NIBBLES uppercase hex
// characters plus an optional separator or CR/LF, streamed over a valid/ready byte port.
module dcp_hex_tx #(
  parameter int          NIBBLES = 8,
  parameter logic [7:0]  SEP     = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic [1:0]  fmt,
  input  logic        vld_in,
  output logic        rdy_in,
  output logic        done,
  output logic        busy,
  input  logic        rdy_tx,
  output logic [7:0]  d_tx,
  output logic        vld_tx
);

  typedef enum logic [2:0] {IDLE, HEX, TAIL, LF, DONE} state_t;

  state_t      state_q;
  logic [31:0] word_q;
  logic [1:0]  fmt_q;
  logic [2:0]  cnt_q;
  logic [7:0]  d_tx_q;
  logic        vld_tx_q;
  logic        done_q;
  logic        busy_q;
  logic        rdy_in_q;

  logic [3:0]  nib_first_d;
  logic [3:0]  nib_next_d;
  logic        xfer_d;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign xfer_d      = vld_tx_q && rdy_tx;
  assign nib_first_d = din[4*NIBBLES-1 -: 4];

  // Nibble printed after the current one; only consumed while cnt_q != 0.
  always_comb begin
    nib_next_d = word_q[3:0];
    for (int i = 0; i < 8; i++) begin
      if (3'(i) == (cnt_q - 3'd1)) nib_next_d = word_q[4*i +: 4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      word_q   <= '0;
      fmt_q    <= '0;
      cnt_q    <= '0;
      d_tx_q   <= 8'h00;
      vld_tx_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      rdy_in_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rdy_in_q <= 1'b1;
          if (vld_in && rdy_in_q) begin
            word_q   <= din;
            fmt_q    <= fmt;
            cnt_q    <= 3'(NIBBLES - 1);
            d_tx_q   <= hex_ascii(nib_first_d);
            vld_tx_q <= 1'b1;
            busy_q   <= 1'b1;
            rdy_in_q <= 1'b0;
            state_q  <= HEX;
          end
        end
        HEX: begin
          if (xfer_d) begin
            if (cnt_q != 3'd0) begin
              cnt_q  <= cnt_q - 3'd1;
              d_tx_q <= hex_ascii(nib_next_d);
            end else if (fmt_q == 2'b00) begin
              vld_tx_q <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              d_tx_q  <= fmt_q[1] ? 8'h0D : SEP;
              state_q <= TAIL;
            end
          end
        end
        TAIL: begin
          if (xfer_d) begin
            if (fmt_q[1]) begin
              d_tx_q  <= 8'h0A;
              state_q <= LF;
            end else begin
              vld_tx_q <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        LF: begin
          if (xfer_d) begin
            vld_tx_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          busy_q   <= 1'b0;
          rdy_in_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          vld_tx_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign rdy_in = rdy_in_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign d_tx   = d_tx_q;
  assign vld_tx = vld_tx_q;

endmodule

// File: tb/tb_dcp_hex_tx.sv
// Directed bench for dcp_hex_tx: one task per scenario, byte streams captured on the
// falling edge and compared against hand-written ASCII strings.
module tb_dcp_hex_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic [1:0]  fmt;
  logic        vld_in;
  logic        rdy_in, done, busy;
  logic        rdy_tx;
  logic [7:0]  d_tx;
  logic        vld_tx;

  logic [31:0] din2;
  logic [1:0]  fmt2;
  logic        vld_in2;
  logic        rdy_in2, done2, busy2;
  logic        rdy_tx2;
  logic [7:0]  d_tx2;
  logic        vld_tx2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] got[$];
  int         xcyc[$];
  int         done_cyc;
  int         stab_viol;
  int         rdyin_viol;
  bit         timed_out;

  always #5 clk = ~clk;

  dcp_hex_tx #(.NIBBLES(8), .SEP(8'h20)) u_dut (
    .clk(clk), .rst(rst), .din(din), .fmt(fmt), .vld_in(vld_in),
    .rdy_in(rdy_in), .done(done), .busy(busy),
    .rdy_tx(rdy_tx), .d_tx(d_tx), .vld_tx(vld_tx)
  );

  dcp_hex_tx #(.NIBBLES(2), .SEP(8'h20)) u_dut2 (
    .clk(clk), .rst(rst), .din(din2), .fmt(fmt2), .vld_in(vld_in2),
    .rdy_in(rdy_in2), .done(done2), .busy(busy2),
    .rdy_tx(rdy_tx2), .d_tx(d_tx2), .vld_tx(vld_tx2)
  );

  // Present a request on the falling edge once the block reports ready.
  task automatic issue(input logic [31:0] w, input logic [1:0] f);
    bit ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rdy_in) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok) $display("FAIL issue_rdy_in got 0 exp 1 (no ready within 50 cycles)");
    else n_pass++;
    din = w;
    fmt = f;
    vld_in = 1'b1;
  endtask

  // mode 0: rdy_tx=1; mode 1: random rdy_tx with 5-cycle low stretches;
  // mode 2: rdy_tx=1 with vld_in held high and din scrambled every cycle.
  task automatic collect(input int mode, input int stop_after);
    bit         prev_hold = 0;
    logic [7:0] prev_d = 8'h00;
    got.delete();
    xcyc.delete();
    done_cyc = -1; stab_viol = 0; rdyin_viol = 0; timed_out = 0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (mode == 2) din = $urandom;
      else vld_in = 1'b0;
      if (mode == 1) rdy_tx = ((n % 11) >= 6) ? 1'b0 : 1'($urandom % 2);
      else rdy_tx = 1'b1;
      if (rdy_in) rdyin_viol++;
      if (prev_hold && (!vld_tx || d_tx !== prev_d)) stab_viol++;
      if (done) begin done_cyc = n; return; end
      prev_hold = vld_tx && !rdy_tx;
      prev_d = d_tx;
      if (vld_tx && rdy_tx) begin
        got.push_back(d_tx);
        xcyc.push_back(n);
        if (got.size() == stop_after) return;
      end
    end
    timed_out = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = '0; fmt = '0; vld_in = 0; rdy_tx = 1;
    din2 = '0; fmt2 = '0; vld_in2 = 0; rdy_tx2 = 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (d_tx !== 8'h00 || vld_tx !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || rdy_in !== 1'b0)
      $display("FAIL reset_outputs got d=%02h v=%b dn=%b bz=%b ri=%b exp 00 0 0 0 0", d_tx, vld_tx, done, busy, rdy_in);
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (rdy_in !== 1'b1 || vld_tx !== 1'b0)
      $display("FAIL reset_release_idle got ri=%b v=%b exp 1 0", rdy_in, vld_tx);
    else n_pass++;
    $display("reset: rdy_in=%b vld_tx=%b", rdy_in, vld_tx);
  endtask

  task automatic test_crlf();
    string s = "1234ABCD";
    issue(32'h1234ABCD, 2'b10);
    collect(0, 0);
    n_checks++;
    if (got.size() != 10) $display("FAIL crlf_count got %0d exp 10", got.size());
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got[i] !== s[i]) $display("FAIL crlf_byte%0d got %02h exp %02h", i, got[i], s[i]);
      else n_pass++;
    end
    n_checks++;
    if (got[8] !== 8'h0D || got[9] !== 8'h0A)
      $display("FAIL crlf_tail got %02h %02h exp 0d 0a", got[8], got[9]);
    else n_pass++;
    n_checks++;
    if (xcyc.size() != 10 || xcyc[0] != 1 || xcyc[9] != 10)
      $display("FAIL crlf_timing got first=%0d last=%0d exp 1 10", xcyc[0], xcyc[9]);
    else n_pass++;
    n_checks++;
    if (done_cyc != 11 || busy !== 1'b1)
      $display("FAIL crlf_done got cyc=%0d busy=%b exp 11 1", done_cyc, busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (rdy_in !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || vld_tx !== 1'b0)
      $display("FAIL crlf_back_idle got ri=%b dn=%b bz=%b v=%b exp 1 0 0 0", rdy_in, done, busy, vld_tx);
    else n_pass++;
    $display("crlf: %0d bytes, done at cycle %0d", got.size(), done_cyc);
  endtask

  task automatic test_sep();
    string s = "0000000F";
    issue(32'h0000000F, 2'b01);
    collect(0, 0);
    n_checks++;
    if (got.size() != 9 || done_cyc < 0) $display("FAIL sep_count got %0d exp 9", got.size());
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got[i] !== s[i]) $display("FAIL sep_byte%0d got %02h exp %02h", i, got[i], s[i]);
      else n_pass++;
    end
    n_checks++;
    if (got[8] !== 8'h20) $display("FAIL sep_tail got %02h exp 20", got[8]);
    else n_pass++;
    $display("sep: %0d bytes", got.size());
  endtask

  task automatic test_backpressure();
    string s = "DEADBEEF";
    issue(32'hDEADBEEF, 2'b00);
    collect(1, 0);
    n_checks++;
    if (got.size() != 8 || timed_out) $display("FAIL bp_count got %0d exp 8", got.size());
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got[i] !== s[i]) $display("FAIL bp_byte%0d got %02h exp %02h", i, got[i], s[i]);
      else n_pass++;
    end
    n_checks++;
    if (stab_viol != 0) $display("FAIL bp_stable got %0d violations exp 0", stab_viol);
    else n_pass++;
    n_checks++;
    if (xcyc.size() != 8 || done_cyc != xcyc[7] + 1)
      $display("FAIL bp_done got cyc=%0d exp %0d", done_cyc, xcyc[7] + 1);
    else n_pass++;
    rdy_tx = 1'b1;
    $display("backpressure: %0d bytes, done at cycle %0d", got.size(), done_cyc);
  endtask

  task automatic test_back_to_back();
    string s1 = "CAFE0123";
    string s2 = "0BADF00D";
    issue(32'hCAFE0123, 2'b01);
    collect(2, 0);
    n_checks++;
    if (got.size() != 9 || rdyin_viol != 0)
      $display("FAIL b2b_first got %0d bytes rdy_in_hi=%0d exp 9 0", got.size(), rdyin_viol);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got[i] !== s1[i]) $display("FAIL b2b_first_byte%0d got %02h exp %02h", i, got[i], s1[i]);
      else n_pass++;
    end
    din = 32'h0BADF00D;
    fmt = 2'b00;
    @(negedge clk);
    n_checks++;
    if (rdy_in !== 1'b1 || busy !== 1'b0)
      $display("FAIL b2b_idle got ri=%b bz=%b exp 1 0", rdy_in, busy);
    else n_pass++;
    collect(0, 0);
    n_checks++;
    if (got.size() != 8) $display("FAIL b2b_second_count got %0d exp 8", got.size());
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got[i] !== s2[i]) $display("FAIL b2b_second_byte%0d got %02h exp %02h", i, got[i], s2[i]);
      else n_pass++;
    end
    $display("back_to_back: second word %0d bytes", got.size());
  endtask

  task automatic test_mid_reset();
    string s = "00000001";
    int stray = 0;
    issue(32'h89ABCDEF, 2'b10);
    collect(0, 3);
    @(posedge clk);
    #2;
    n_checks++;
    if (vld_tx !== 1'b1 || d_tx !== 8'h42)
      $display("FAIL mrst_before got v=%b d=%02h exp 1 42", vld_tx, d_tx);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (vld_tx !== 1'b0 || d_tx !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || rdy_in !== 1'b0)
      $display("FAIL mrst_async got v=%b d=%02h bz=%b dn=%b ri=%b exp 0 00 0 0 0", vld_tx, d_tx, busy, done, rdy_in);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (vld_tx) stray++;
    end
    n_checks++;
    if (stray != 0) $display("FAIL mrst_no_tail got %0d stray bytes exp 0", stray);
    else n_pass++;
    issue(32'h00000001, 2'b00);
    collect(0, 0);
    n_checks++;
    if (got.size() != 8 || done_cyc < 0) $display("FAIL mrst_after_count got %0d exp 8", got.size());
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got[i] !== s[i]) $display("FAIL mrst_after_byte%0d got %02h exp %02h", i, got[i], s[i]);
      else n_pass++;
    end
    $display("mid_reset: restart word %0d bytes", got.size());
  endtask

  task automatic test_nibbles2();
    logic [7:0] g2[$];
    logic [7:0] e2[4] = '{8'h35, 8'h41, 8'h0D, 8'h0A};
    bit seen_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rdy_in2) break;
    end
    din2 = 32'hFFFF005A;
    fmt2 = 2'b11;
    vld_in2 = 1'b1;
    rdy_tx2 = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      vld_in2 = 1'b0;
      if (done2) begin seen_done = 1; break; end
      if (vld_tx2 && rdy_tx2) g2.push_back(d_tx2);
    end
    n_checks++;
    if (g2.size() != 4 || !seen_done) $display("FAIL nib2_count got %0d done=%b exp 4 1", g2.size(), seen_done);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (g2[i] !== e2[i]) $display("FAIL nib2_byte%0d got %02h exp %02h", i, g2[i], e2[i]);
      else n_pass++;
    end
    $display("nibbles2: %0d bytes", g2.size());
  endtask

  initial begin
    test_reset();
    test_crlf();
    test_sep();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_nibbles2();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
